fwd_hazard_ctrl: RTL

Operand-hazard controller for the five-stage integer pipeline (ID, EX, MEM1, MEM2, WB). It tracks in-flight register writers in a small shift-register scoreboard and generates the bypass selects for the EX-stage operand muxes (mux4/mux5) and the ID-stage early-compare muxes (mux8/mux9). When no bypass source is ready, it asserts a load-use/latency stall that holds ID and injects a bubble into EX.

---
 rtl/fwd_hazard_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/fwd_hazard_ctrl.sv
// Operand-hazard controller: E/M1/M2/W writer scoreboard, EX and ID bypass
// selects, and the load-use / latency stall for a five-stage pipeline.
module fwd_hazard_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       id_early_rs,
  input  logic       id_early_rt,
  input  logic       id_wr_en,
  input  logic [4:0] id_wr_addr,
  input  logic [2:0] id_wr_src,
  input  logic       pipe_hold,
  input  logic       flush,
  output logic       stall,
  output logic [1:0] ex_mux4_sel,
  output logic [1:0] ex_mux5_sel,
  output logic [1:0] id_mux8_sel,
  output logic [1:0] id_mux9_sel
);

  typedef enum logic [1:0] {
    CLS_ALU  = 2'b00,
    CLS_MUL  = 2'b01,
    CLS_LATE = 2'b10
  } cls_t;

  // Writeback-source code to producer readiness class.
  function automatic cls_t decode_class(input logic [2:0] src);
    cls_t c;
    case (src)
      3'b100, 3'b101, 3'b111: c = CLS_LATE;
      3'b110:                 c = CLS_MUL;
      default:                c = CLS_ALU;
    endcase
    return c;
  endfunction

  // Result is {stall, sel}; resolves one EX operand for the next cycle.
  function automatic logic [2:0] ex_resolve(input logic use_src, input logic [3:0] hit,
                                            input cls_t cls_e, input cls_t cls_m1);
    logic [2:0] r;
    if (!use_src) begin
      r = 3'b000;
    end else if (hit[0]) begin
      r = (cls_e == CLS_ALU) ? 3'b001 : 3'b100;
    end else if (hit[1]) begin
      r = (cls_m1 == CLS_LATE) ? 3'b100 : 3'b011;
    end else begin
      r = 3'b000;
    end
    return r;
  endfunction

  // Result is {stall, sel}; resolves one ID early-compare operand now.
  function automatic logic [2:0] early_resolve(input logic use_src, input logic [3:0] hit,
                                               input cls_t cls_m1, input cls_t cls_m2);
    logic [2:0] r;
    if (!use_src) begin
      r = 3'b000;
    end else if (hit[0]) begin
      r = 3'b100;
    end else if (hit[1]) begin
      r = (cls_m1 == CLS_ALU) ? 3'b010 : 3'b100;
    end else if (hit[2]) begin
      r = (cls_m2 == CLS_LATE) ? 3'b100 : 3'b011;
    end else if (hit[3]) begin
      r = 3'b001;
    end else begin
      r = 3'b000;
    end
    return r;
  endfunction

  // Index 0 = E, 1 = M1, 2 = M2, 3 = W. W class is never consulted.
  logic [3:0] sb_valid_r;
  logic [4:0] sb_addr_r [4];
  cls_t       sb_cls_r  [3];

  logic [3:0] rs_hit_s;
  logic [3:0] rt_hit_s;
  logic [2:0] ex_rs_s;
  logic [2:0] ex_rt_s;
  logic [2:0] early_rs_s;
  logic [2:0] early_rt_s;
  logic       advance_s;
  logic       load_e_s;

  // Source-versus-entry match vectors; r0 never matches.
  always_comb begin
    rs_hit_s = 4'b0000;
    rt_hit_s = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      rs_hit_s[i] = sb_valid_r[i] & (sb_addr_r[i] == id_rs) & (id_rs != 5'd0);
      rt_hit_s[i] = sb_valid_r[i] & (sb_addr_r[i] == id_rt) & (id_rt != 5'd0);
    end
  end

  // Bypass resolution, stall, and the advance/load qualifiers.
  always_comb begin
    ex_rs_s    = ex_resolve(id_use_rs, rs_hit_s, sb_cls_r[0], sb_cls_r[1]);
    ex_rt_s    = ex_resolve(id_use_rt, rt_hit_s, sb_cls_r[0], sb_cls_r[1]);
    early_rs_s = early_resolve(id_early_rs, rs_hit_s, sb_cls_r[1], sb_cls_r[2]);
    early_rt_s = early_resolve(id_early_rt, rt_hit_s, sb_cls_r[1], sb_cls_r[2]);
    stall      = id_valid & (ex_rs_s[2] | ex_rt_s[2] | early_rs_s[2] | early_rt_s[2]);
    advance_s  = id_valid & ~stall & ~flush;
    load_e_s   = advance_s & id_wr_en;
  end

  // A stalled early operand drives 00 instead of a stale select.
  always_comb begin
    id_mux8_sel = early_rs_s[1:0];
    id_mux9_sel = early_rt_s[1:0];
  end

  // Scoreboard shift and registered EX selects; a flush kills the EX occupant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_valid_r  <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        sb_addr_r[i] <= 5'd0;
      end
      for (int i = 0; i < 3; i++) begin
        sb_cls_r[i] <= CLS_ALU;
      end
      ex_mux4_sel <= 2'b00;
      ex_mux5_sel <= 2'b00;
    end else if (!pipe_hold) begin
      sb_valid_r   <= {sb_valid_r[2], sb_valid_r[1], sb_valid_r[0] & ~flush, load_e_s};
      sb_addr_r[3] <= sb_addr_r[2];
      sb_addr_r[2] <= sb_addr_r[1];
      sb_addr_r[1] <= sb_addr_r[0];
      sb_addr_r[0] <= load_e_s ? id_wr_addr : 5'd0;
      sb_cls_r[2]  <= sb_cls_r[1];
      sb_cls_r[1]  <= sb_cls_r[0];
      sb_cls_r[0]  <= load_e_s ? decode_class(id_wr_src) : CLS_ALU;
      ex_mux4_sel  <= advance_s ? ex_rs_s[1:0] : 2'b00;
      ex_mux5_sel  <= advance_s ? ex_rt_s[1:0] : 2'b00;
    end
  end

endmodule
